// File: rtl/lc3_mem_responder.sv
// ============================================================================
// Module   : lc3_mem_responder
// Function : LC-3 MAR/MDR memory responder; SRAM wait-state sequencer plus
//            one memory-mapped I/O address (switch read / hex-display write).
// Revision : 1.0
// ============================================================================
`default_nettype none

module lc3_mem_responder #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        Req,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        R,
    output logic [15:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    input  logic [15:0] Switches,
    output logic [15:0] HEX_Data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dq_q, dq_d;

    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            rdata_q <= 16'h0000;
            hex_q   <= 16'h0000;
            addr_q  <= 16'h0000;
            dq_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        addr_d  = addr_q;
        dq_d    = dq_q;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d = ADDR;
                    dq_d   = WDATA;
                    we_d   = WE;
                    // The I/O address never touches the SRAM pins.
                    if (ADDR == IO_ADDR) begin
                        if (WE) hex_d   = WDATA;
                        else    rdata_d = Switches;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) rdata_d = SRAM_DQ_in;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = Req ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (!Req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset drops them at once.
    logic access_w;
    assign access_w    = (state_q == S_ACCESS);
    assign R           = (state_q == S_DONE);
    assign SRAM_CE_N   = !access_w;
    assign SRAM_OE_N   = !(access_w && !we_q);
    assign SRAM_WE_N   = !(access_w && we_q);
    assign SRAM_DQ_oe  = access_w && we_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = dq_q;
    assign RDATA       = rdata_q;
    assign HEX_Data    = hex_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
// ============================================================================
// Module   : tb_lc3_mem_responder
// Function : Randomised scoreboard bench for lc3_mem_responder with an SRAM
//            pin model and a transaction-level reference memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lc3_mem_responder;

    localparam int          W   = 2;
    localparam logic [15:0] IOA = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset_ah = 1'b0;
    logic        Req = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] WDATA = 16'h0000;
    logic [15:0] RDATA;
    logic        R;
    logic [15:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] Switches = 16'h0000;
    logic [15:0] HEX_Data;

    lc3_mem_responder #(.WAIT_CYCLES(W), .IO_ADDR(IOA)) dut (
        .Clk(Clk), .Reset_ah(Reset_ah), .Req(Req), .WE(WE), .ADDR(ADDR),
        .WDATA(WDATA), .RDATA(RDATA), .R(R), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_DQ_in(SRAM_DQ_in), .Switches(Switches), .HEX_Data(HEX_Data)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] fill_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // External SRAM pin model: unwritten locations return a fixed pattern.
    logic [15:0] sram_mem [0:65535];
    bit          sram_wr  [0:65535];
    assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N)
                      ? (sram_wr[SRAM_ADDR] ? sram_mem[SRAM_ADDR] : fill_val(SRAM_ADDR))
                      : 16'hDEAD;
    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe) begin
            sram_mem[SRAM_ADDR] <= SRAM_DQ_out;
            sram_wr[SRAM_ADDR]  <= 1'b1;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        bit          io;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [15:0] hex;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] m_rdata = 16'h0000;
    logic [15:0] m_hex   = 16'h0000;

    // Monitor: checks pin behaviour every cycle and retires one entry per R pulse.
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_ah) begin
            if (SRAM_DQ_oe && !SRAM_OE_N)
                chk("oe_dq_conflict", 1, 0);
            if (R) begin
                if (sb.size() == 0) begin
                    chk("unexpected_R", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", RDATA, e.rdata);
                    chk("hex", HEX_Data, e.hex);
                    chk("r_cycle", cyc, e.due);
                end
            end else if (sb.size() == 0 || sb[0].io) begin
                chk("ce_idle", SRAM_CE_N, 1);
            end else if (!SRAM_CE_N) begin
                chk("sram_addr", SRAM_ADDR, sb[0].addr);
                if (sb[0].we) begin
                    chk("wr_strobes", {SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe}, 3'b101);
                    chk("dq_out", SRAM_DQ_out, sb[0].wdata);
                end else begin
                    chk("rd_strobes", {SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe}, 3'b010);
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int hold, input bit drop_early);
        exp_t e;
        int   waited;
        @(negedge Clk);
        Req = 1'b1; WE = we; ADDR = addr; WDATA = wdata;
        Switches = 16'($urandom);
        e.io = (addr == IOA);
        e.we = we; e.addr = addr; e.wdata = wdata;
        if (e.io) begin
            if (we) m_hex = wdata;
            else    m_rdata = Switches;
        end else begin
            if (we) ref_mem[addr] = wdata;
            else    m_rdata = ref_mem[addr];
        end
        e.rdata = m_rdata;
        e.hex   = m_hex;
        e.due   = cyc + (e.io ? 1 : W + 1);
        sb.push_back(e);
        @(negedge Clk);
        // Inputs after capture must have no effect.
        ADDR = 16'($urandom); WDATA = 16'($urandom); WE = 1'($urandom);
        if (drop_early) Req = 1'b0;
        waited = 0;
        while (!R && waited < 40) begin
            @(negedge Clk);
            waited++;
        end
        if (!R) begin
            chk("r_timeout", 0, 1);
            sb.delete();
        end
        repeat (hold) @(negedge Clk);
        Req = 1'b0;
        @(negedge Clk);
    endtask

    task automatic rand_txn();
        int          sel;
        logic [15:0] a;
        bit          io;
        sel = $urandom_range(0, 9);
        a   = 16'($urandom);
        if (sel < 2)       a = IOA;
        else if (sel == 2) a = 16'hFFFE;
        else if (sel == 3) a = 16'h0000;
        else if (a == IOA) a = 16'hFFFE;
        io = (a == IOA);
        issue(1'($urandom), a, 16'($urandom), $urandom_range(0, 3),
              !io && ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = fill_val(16'(i));
        #1 Reset_ah = 1'b1;
        #1;
        chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe, R}, 5'b11100);
        chk("rst_rdata", RDATA, 16'h0000);
        chk("rst_hex", HEX_Data, 16'h0000);
        chk("rst_addr_dq", {SRAM_ADDR, SRAM_DQ_out}, 32'h0);
        repeat (2) @(negedge Clk);
        chk("rst_held_R", R, 0);
        Reset_ah = 1'b0;

        issue(1'b1, 16'h0030, 16'hBEEF, 0, 1'b0);
        issue(1'b0, 16'h0030, 16'h0000, 0, 1'b0);
        issue(1'b1, 16'h1234, 16'hA5A5, 1, 1'b0);
        issue(1'b1, IOA, 16'h00C3, 0, 1'b0);
        issue(1'b0, IOA, 16'h0000, 0, 1'b0);
        issue(1'b0, 16'h1234, 16'h0000, 6, 1'b0);
        issue(1'b0, 16'hFFFE, 16'h0000, 0, 1'b1);
        issue(1'b1, 16'h0000, 16'h7E57, 2, 1'b0);
        issue(1'b0, 16'h0000, 16'h0000, 0, 1'b0);

        for (int i = 0; i < 60; i++) rand_txn();
        issue(1'b1, IOA, 16'h0F0F, 0, 1'b0);
        issue(1'b0, 16'h1234, 16'h0000, 0, 1'b0);

        // Abort a write in its first access cycle.
        @(negedge Clk);
        Req = 1'b1; WE = 1'b1; ADDR = 16'h0400; WDATA = 16'h1111;
        @(posedge Clk);
        #1;
        chk("abort_we_active", SRAM_WE_N, 0);
        Reset_ah = 1'b1;
        #1;
        chk("abort_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_oe, R}, 4'b1100);
        chk("abort_rdata", RDATA, 16'h0000);
        chk("abort_hex", HEX_Data, 16'h0000);
        Req = 1'b0;
        m_rdata = 16'h0000;
        m_hex   = 16'h0000;
        repeat (2) begin
            @(negedge Clk);
            chk("abort_no_R", R, 0);
        end
        Reset_ah = 1'b0;

        issue(1'b0, 16'h0400, 16'h0000, 0, 1'b0);
        for (int i = 0; i < 20; i++) rand_txn();
        repeat (3) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
